// File: rtl/l4_stream_pkg.sv
// Shared constants and types for the layer-4 pooled-feature streamer.
package l4_stream_pkg;

    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_FETCH = 4'b0010;
    localparam logic [3:0] S_DRAIN = 4'b0100;
    localparam logic [3:0] S_DONE  = 4'b1000;

    localparam int unsigned BANK_DEPTH     = 200;
    localparam int unsigned TOTAL_FEATURES = 2 * BANK_DEPTH;

    typedef enum logic {
        BANK_1 = 1'b0,
        BANK_2 = 1'b1
    } bank_sel_t;

endpackage

// File: rtl/feat_skid_fifo.sv
// Small synchronous FIFO with async active-low reset and a synchronous flush.
module feat_skid_fifo #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop  = pop && (cnt != '0);
        do_push = push && ((cnt != FULL_CNT) || do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: the head is only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
    assign count = cnt;

endmodule

// File: rtl/l4_feature_streamer.sv
// Reads both L4 pooled-output banks in flattened order and streams them to layer 5.
module l4_feature_streamer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BANK_DEPTH = l4_stream_pkg::BANK_DEPTH,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IDX_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  L4_en,
    input  logic [DATA_WIDTH-1:0] L4_output_read_data1,
    input  logic [DATA_WIDTH-1:0] L4_output_read_data2,
    output logic [ADDR_WIDTH-1:0] L4_output_read_addr,
    output logic                  feat_valid,
    input  logic                  feat_ready,
    output logic [DATA_WIDTH-1:0] feat_data,
    output logic [IDX_WIDTH-1:0]  feat_index,
    output logic                  feat_last,
    output logic                  L4_read_done,
    output logic                  busy
);

    import l4_stream_pkg::*;

    localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CR_W    = FCNT_W + 1;
    localparam int unsigned ENTRY_W = DATA_WIDTH + IDX_WIDTH + 1;
    localparam logic [CR_W-1:0]       CREDIT_LIMIT = CR_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR    = ADDR_WIDTH'(BANK_DEPTH - 1);
    localparam logic [IDX_WIDTH-1:0]  BANK2_BASE   = IDX_WIDTH'(BANK_DEPTH);
    localparam logic [IDX_WIDTH-1:0]  LAST_INDEX   = IDX_WIDTH'(2 * BANK_DEPTH - 1);

    logic [3:0]            state;
    logic [3:0]            state_next;
    logic [ADDR_WIDTH-1:0] rd_addr;
    bank_sel_t             bank_sel;
    logic                  issue;
    logic                  abort;
    logic                  pop;
    logic                  drain_empty;
    logic [CR_W-1:0]       inflight;

    logic                  pipe_v    [RD_LAT];
    bank_sel_t             pipe_bank [RD_LAT];
    logic [ADDR_WIDTH-1:0] pipe_addr [RD_LAT];

    logic [DATA_WIDTH-1:0] push_data;
    logic [IDX_WIDTH-1:0]  push_index;
    logic                  push_last;

    logic                  fifo_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FCNT_W-1:0]     fifo_count;
    logic [ENTRY_W-1:0]    fifo_head;
    logic [DATA_WIDTH-1:0] head_data;
    logic [IDX_WIDTH-1:0]  head_index;
    logic                  head_last;

    // Credit check counts words already queued plus reads whose data is still in the BRAM pipe.
    always_comb begin
        issue       = (state == S_FETCH) && L4_en &&
                      ((CR_W'(fifo_count) + inflight) < CREDIT_LIMIT);
        abort       = !L4_en && ((state == S_FETCH) || (state == S_DRAIN));
        pop         = feat_valid && feat_ready;
        drain_empty = (inflight == '0) &&
                      ((fifo_count == '0) || ((fifo_count == FCNT_W'(1)) && pop));
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (L4_en) state_next = S_FETCH;
            S_FETCH: begin
                if (!L4_en)
                    state_next = S_IDLE;
                else if (issue && (bank_sel == BANK_2) && (rd_addr == LAST_ADDR))
                    state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!L4_en)
                    state_next = S_IDLE;
                else if (drain_empty)
                    state_next = S_DONE;
            end
            S_DONE:  if (!L4_en) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // The bank select stays on bank 2 through DRAIN/DONE so it switches once per pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr  <= '0;
            bank_sel <= BANK_1;
        end else if (state_next != S_FETCH) begin
            rd_addr <= '0;
            if (state_next == S_IDLE) bank_sel <= BANK_1;
        end else if (issue) begin
            if (rd_addr == LAST_ADDR) begin
                rd_addr  <= '0;
                bank_sel <= BANK_2;
            end else begin
                rd_addr <= rd_addr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_v[i]    <= 1'b0;
                pipe_bank[i] <= BANK_1;
                pipe_addr[i] <= '0;
            end
        end else if (abort) begin
            for (int unsigned i = 0; i < RD_LAT; i++) pipe_v[i] <= 1'b0;
        end else begin
            pipe_v[0]    <= issue;
            pipe_bank[0] <= bank_sel;
            pipe_addr[0] <= rd_addr;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_bank[i] <= pipe_bank[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            inflight <= '0;
        else if (abort)
            inflight <= '0;
        else if (issue && !fifo_push)
            inflight <= inflight + 1'b1;
        else if (!issue && fifo_push)
            inflight <= inflight - 1'b1;
    end

    always_comb begin
        fifo_push  = pipe_v[RD_LAT-1];
        push_data  = (pipe_bank[RD_LAT-1] == BANK_2) ? L4_output_read_data2
                                                     : L4_output_read_data1;
        push_index = (pipe_bank[RD_LAT-1] == BANK_2)
                     ? BANK2_BASE + IDX_WIDTH'(pipe_addr[RD_LAT-1])
                     : IDX_WIDTH'(pipe_addr[RD_LAT-1]);
        push_last  = (push_index == LAST_INDEX);
    end

    feat_skid_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .push      (fifo_push),
        .push_data ({push_last, push_index, push_data}),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign {head_last, head_index, head_data} = fifo_head;

    assign feat_valid          = !fifo_empty;
    assign feat_data           = fifo_empty ? '0 : head_data;
    assign feat_index          = fifo_empty ? '0 : head_index;
    assign feat_last           = !fifo_empty && head_last;
    assign L4_output_read_addr = rd_addr;
    assign L4_read_done        = (state == S_DONE);
    assign busy                = (state == S_FETCH) || (state == S_DRAIN);

endmodule

// File: tb/tb_l4_feature_streamer.sv
// Scoreboard bench: expected 400-word stream built from the bank contents, checked by a monitor.
module tb_l4_feature_streamer;

    import l4_stream_pkg::*;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int BD = 200;
    localparam int RL = 2;
    localparam int FD = 4;
    localparam int IW = 9;
    localparam int NF = 400;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          L4_en = 1'b0;
    logic          feat_ready = 1'b0;
    logic [DW-1:0] rd1, rd2;
    logic [AW-1:0] raddr;
    logic          feat_valid, feat_last, done, busy;
    logic [DW-1:0] feat_data;
    logic [IW-1:0] feat_index;

    l4_feature_streamer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .BANK_DEPTH (BD),
        .RD_LAT     (RL),
        .FIFO_DEPTH (FD),
        .IDX_WIDTH  (IW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .L4_en                (L4_en),
        .L4_output_read_data1 (rd1),
        .L4_output_read_data2 (rd2),
        .L4_output_read_addr  (raddr),
        .feat_valid           (feat_valid),
        .feat_ready           (feat_ready),
        .feat_data            (feat_data),
        .feat_index           (feat_index),
        .feat_last            (feat_last),
        .L4_read_done         (done),
        .busy                 (busy)
    );

    initial forever #5 clk = ~clk;

    // BRAM model: data appears RL cycles after the address.
    logic [DW-1:0] mem1 [BD];
    logic [DW-1:0] mem2 [BD];
    logic [DW-1:0] lat1 [RL];
    logic [DW-1:0] lat2 [RL];

    always @(posedge clk) begin
        lat1[0] <= (int'(raddr) < BD) ? mem1[raddr] : '0;
        lat2[0] <= (int'(raddr) < BD) ? mem2[raddr] : '0;
        for (int i = 1; i < RL; i++) begin
            lat1[i] <= lat1[i-1];
            lat2[i] <= lat2[i-1];
        end
    end
    assign rd1 = lat1[RL-1];
    assign rd2 = lat2[RL-1];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   idx;
        bit            last;
    } exp_t;

    exp_t      exp_q[$];
    int        rd_n = 0;
    int        bank_sw = 0;
    bank_sel_t prev_bank = BANK_1;

    function automatic exp_t model_word(int unsigned k);
        exp_t e;
        e.data = (k < BD) ? mem1[k] : mem2[k - BD];
        e.idx  = k;
        e.last = (k == NF - 1);
        return e;
    endfunction

    task automatic start_run();
        exp_q.delete();
        for (int unsigned k = 0; k < NF; k++) exp_q.push_back(model_word(k));
        rd_n    = 0;
        bank_sw = 0;
        L4_en   = 1'b1;
    endtask

    // 0: ready high, 1: 1-0-0-1 pattern, 2: random, 3: held low
    int rmode = 0;
    int pat = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0: feat_ready = 1'b1;
            1: begin
                feat_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
                pat++;
            end
            2: feat_ready = 1'($urandom_range(0, 1));
            default: feat_ready = 1'b0;
        endcase
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            if (feat_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got index %0d, expected no word", feat_index);
                end else begin
                    exp_t e;
                    e = exp_q[0];
                    check("feat_data", feat_data, e.data);
                    check("feat_index", feat_index, e.idx);
                    check("feat_last", feat_last, e.last);
                    if (feat_ready) void'(exp_q.pop_front());
                end
            end
            if (dut.issue) begin
                check("rd_addr", raddr, rd_n % BD);
                check("rd_bank", dut.bank_sel, rd_n >= BD);
                rd_n++;
            end
            if (busy && dut.bank_sel != prev_bank) bank_sw++;
            check("credit", (int'(dut.fifo_count) + int'(dut.inflight)) <= FD, 1);
            check("push_full", dut.fifo_push && dut.fifo_full, 0);
        end
        prev_bank = dut.bank_sel;
    end

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("done_reached", done, 1);
    endtask

    task automatic wait_index(int unsigned k, string name);
        int c = 0;
        while (!(feat_valid && feat_index == k) && c < 1000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check(name, feat_valid && (feat_index == k), 1);
    endtask

    task automatic end_of_run_checks();
        check("queue_empty", exp_q.size(), 0);
        check("read_count", rd_n, NF);
        check("bank_switches", bank_sw, 1);
    endtask

    task automatic leave_done();
        L4_en = 1'b0;
        @(posedge clk);
        #1;
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
    endtask

    task automatic fill_random();
        for (int a = 0; a < BD; a++) begin
            mem1[a] = DW'($urandom);
            mem2[a] = DW'($urandom);
        end
    endtask

    int cyc;

    initial begin
        for (int a = 0; a < BD; a++) begin
            mem1[a] = DW'(a);
            mem2[a] = DW'(1000 + a);
        end
        #1 rst = 1'b0;
        #3;
        check("rst_valid", feat_valid, 0);
        check("rst_data", feat_data, 0);
        check("rst_index", feat_index, 0);
        check("rst_last", feat_last, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", raddr, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Full throughput with ramp data, then DONE hold
        rmode = 0;
        @(posedge clk);
        #1 start_run();
        @(posedge clk);
        #1;
        check("fetch_entry_busy", busy, 1);
        wait_done(cyc);
        check("done_latency", cyc, NF + RL + 1);
        end_of_run_checks();
        repeat (20) begin
            @(posedge clk);
            #1;
            check("done_hold", done, 1);
            check("done_addr", raddr, 0);
        end
        check("done_no_reads", rd_n, NF);
        leave_done();

        // Backpressure 1-0-0-1
        fill_random();
        rmode = 1;
        @(posedge clk);
        #1 start_run();
        wait_done(cyc);
        end_of_run_checks();
        leave_done();

        // Stall across the bank boundary
        fill_random();
        rmode = 2;
        @(posedge clk);
        #1 start_run();
        wait_index(198, "reach_198");
        rmode = 3;
        repeat (8) @(posedge clk);
        #1 rmode = 0;
        wait_done(cyc);
        end_of_run_checks();
        leave_done();

        // Abort at index 57, then restart
        fill_random();
        rmode = 2;
        @(posedge clk);
        #1 start_run();
        wait_index(57, "reach_57");
        L4_en = 1'b0;
        @(posedge clk);
        #1;
        check("abort_state", dut.state, S_IDLE);
        check("abort_valid", feat_valid, 0);
        check("abort_fifo", dut.fifo_count, 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rmode = 0;
        start_run();
        wait_done(cyc);
        end_of_run_checks();
        leave_done();

        // Async reset during DRAIN
        fill_random();
        rmode = 1;
        @(posedge clk);
        #1 start_run();
        cyc = 0;
        while (dut.state != S_DRAIN && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("reach_drain", dut.state, S_DRAIN);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", feat_valid, 0);
        check("arst_data", feat_data, 0);
        check("arst_index", feat_index, 0);
        check("arst_last", feat_last, 0);
        check("arst_done", done, 0);
        check("arst_busy", busy, 0);
        check("arst_addr", raddr, 0);
        check("arst_state", dut.state, S_IDLE);
        L4_en = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_arst_valid", feat_valid, 0);
        check("post_arst_state", dut.state, S_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/l4_feature_streamer.md
Name: l4_feature_streamer

Overview:
Reader at the far end of the layer-4 pooled-output block memories, which layer-3 pooling fills. After layer 3 finishes, it reads both L4 banks (bank 1 = channels 0..7, bank 2 = channels 8..15, 25 words each) and streams the 400 pooled features in flattened order to the layer-5 fully-connected stage over a valid/ready handshake. It absorbs BRAM read latency and downstream backpressure with a credit-limited skid FIFO.

Parameters:
DATA_WIDTH, 16, feature word width
ADDR_WIDTH, 8, L4 bank address width
BANK_DEPTH, 200, words per bank (8 channels x 25)
RD_LAT, 2, BRAM address-to-data latency in cycles
FIFO_DEPTH, 4, skid FIFO entries; must be >= RD_LAT+1
IDX_WIDTH, 9, width of flattened feature index (0..399)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
L4_en  in  1  level enable; rises after L3_done, held until consumer finishes
L4_output_read_data1  in  DATA_WIDTH  bank 1 read data
L4_output_read_data2  in  DATA_WIDTH  bank 2 read data
L4_output_read_addr  out  ADDR_WIDTH  shared read address to both banks
feat_valid  out  1  feature word available
feat_ready  in  1  consumer accepts when valid&ready
feat_data  out  DATA_WIDTH  feature value
feat_index  out  IDX_WIDTH  flattened index of feat_data
feat_last  out  1  high with index 399
L4_read_done  out  1  high in DONE state
busy  out  1  high in FETCH or DRAIN

Behaviour:
- Reset (rst=0, async): FSM=IDLE, read addr=0, bank select=1, FIFO empty, in-flight count=0; all outputs 0.
- FSM states: IDLE, FETCH, DRAIN, DONE (one-hot).
- IDLE -> FETCH when L4_en=1.
- FETCH: issue a read in a cycle only if fifo_count + inflight < FIFO_DEPTH. Order: bank 1 addr 0..199, then bank 2 addr 0..199. After the issue at bank 2 addr 199, go to DRAIN.
- DRAIN -> DONE when inflight=0 and FIFO empty, i.e. the final word (index 399) has been accepted.
- DONE: stay while L4_en=1; L4_en=0 -> IDLE.
- L4_en=0 in FETCH or DRAIN aborts: next cycle is IDLE; FIFO flushed; in-flight data discarded via a valid pipe cleared on abort.
- Read pipeline: issue flag and bank select delayed RD_LAT cycles. At the end of the pipe, push the data of the selected bank and the matching index (bank*200 + addr).
- No read is issued in a cycle where it would overflow the FIFO, so the credit check guarantees no overflow. Push into a full FIFO is unreachable; the bench asserts it never occurs.
- Simultaneous push and pop in one cycle: count unchanged, both take effect.
- Output: feat_valid = FIFO not empty; feat_data, feat_index and feat_last come from the FIFO head, registered.
- Data is stable while valid=1 and ready=0.
- Full throughput: with ready held at 1, one word per cycle after RD_LAT+1 cycles of startup latency. 400 words take 400 + RD_LAT + 1 cycles from the FETCH entry.
- L4_output_read_addr holds its last value when no read is issued, and is 0 outside FETCH.
- Index arithmetic is unsigned IDX_WIDTH bits. Bank 2 offset is the constant BANK_DEPTH. No wrap past 399.

Decomposition:
- Shared package l4_stream_pkg holds:
  - FSM state encodings (S_IDLE=4'b0001, S_FETCH=4'b0010, S_DRAIN=4'b0100, S_DONE=4'b1000)
  - BANK_DEPTH and TOTAL_FEATURES=400
  - the bank-select enum
- One sub-module, feat_skid_fifo: synchronous FIFO, parameterised width and depth. It has push/pop, count, and an async active-low reset plus a sync flush.
- The top level holds the FSM, address generator, credit counter and latency pipe.

Test Plan:
- Reset, then L4_en=1 with ready held at 1. Preload bank1[a]=a and bank2[a]=1000+a. Required: 400 words; word k is k for k<200 and 1000+k-200 for k>=200. feat_last only at index 399. L4_read_done asserts at cycle 403 after FETCH entry.
- Backpressure: ready toggles 1-0-0-1 repeatedly. Required: no word lost or duplicated, data stable while stalled, inflight+count never exceeds 4, the full 400-word sequence is correct.
- Bank boundary: hold ready=0 around index 199/200. Required: feat_index 199 carries bank1[199] and 200 carries bank2[0], with addr wrapping 199->0 and the bank select switching once.
- Abort: drop L4_en at index 57. Required: IDLE next cycle, feat_valid=0, FIFO empty. Re-raise L4_en: the stream restarts from index 0.
- Async reset mid-DRAIN: assert rst=0 between clock edges. Required: all outputs 0 immediately, FSM IDLE.
- DONE hold: keep L4_en=1 for 20 cycles after completion. Required: L4_read_done stays 1, no new reads. L4_en=0 -> IDLE and L4_read_done=0 next cycle.
